// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for serial_subtractor.
// master: operand source and result consumer. slave: the subtractor.
interface serial_subtractor_if #(
   parameter int WIDTH = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             b_in;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] diff;
   logic             b_out;

   modport master (
      output in_valid, a, b, b_in, out_ready,
      input  in_ready, out_valid, diff, b_out
   );

   modport slave (
      input  in_valid, a, b, b_in, out_ready,
      output in_ready, out_valid, diff, b_out
   );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - borrow, LSB first, one bit per clock.
// Optional macro SERIAL_SUB_CHAIN_EN: the borrow loaded at acceptance comes
// from the previous operation's b_out (multi-word chaining) instead of b_in.
module serial_subtractor #(
   parameter int WIDTH = 4
) (
   input logic               clk,
   input logic               rst,
   serial_subtractor_if.slave bus
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_sh, b_sh, part, diff_r;
   logic [CW-1:0]    cnt;
   logic             br, b_out_r;
   logic             d, br_nxt, last, br_src;

`ifdef SERIAL_SUB_CHAIN_EN
   logic chain;
   assign br_src = chain;
`else
   assign br_src = bus.b_in;
`endif

   // one full-subtractor slice on bit 0 of the operand shift registers
   assign d      = a_sh[0] ^ b_sh[0] ^ br;
   assign br_nxt = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
   assign last   = (cnt == CW'(WIDTH - 1));

   // handshake flags come straight from registered state
   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == DONE);
   assign bus.diff      = diff_r;
   assign bus.b_out     = b_out_r;

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // next-state decode
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.in_valid)  state_nxt = SHIFT;
         SHIFT:   if (last)          state_nxt = DONE;
         DONE:    if (bus.out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // datapath: operand capture, per-bit shift, result publish on last bit
   always_ff @(posedge clk) begin
      if (rst) begin
         a_sh    <= '0;
         b_sh    <= '0;
         part    <= '0;
         diff_r  <= '0;
         cnt     <= '0;
         br      <= 1'b0;
         b_out_r <= 1'b0;
`ifdef SERIAL_SUB_CHAIN_EN
         chain   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  a_sh <= bus.a;
                  b_sh <= bus.b;
                  br   <= br_src;
                  cnt  <= '0;
                  part <= '0;
               end
            end
            SHIFT: begin
               a_sh <= a_sh >> 1;
               b_sh <= b_sh >> 1;
               br   <= br_nxt;
               cnt  <= cnt + 1'b1;
               part <= {d, part[WIDTH-1:1]};
               if (last) begin
                  diff_r  <= {d, part[WIDTH-1:1]};
                  b_out_r <= br_nxt;
`ifdef SERIAL_SUB_CHAIN_EN
                  chain   <= br_nxt;
`endif
               end
            end
            default: ;
         endcase
      end
   end
endmodule
